reg_bank_ctrl: RTL and testbench

- Initiator side of the sixteen-bit register interface: sequences writes and reads into a bank of NREGS sixteen-bit registers over their R_W / Ea / D / Qa pins.
- Upstream: valid/ready request channel and a valid/ready response channel.
- Downstream: one R_W strobe and one Ea enable per register, a shared D write bus and a shared Qa read bus.
- Sits between the ALU sequencer and the register bank; the only block that drives register strobes.

---
 rtl/reg_bank_ctrl.sv | 108 ++++++++++
 tb/tb_reg_bank_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: sequences single writes/reads into a register bank over RW/EA/D/QA; `WRITE_READBACK_EN verifies each write by reading it back
module reg_bank_ctrl #(
  parameter int NREGS = 4,
  parameter int W = 16,
  parameter int IDXW = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [IDXW-1:0]  req_idx,
  input  logic [W-1:0]     req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_rdata,
  output logic             rsp_err,
  output logic [NREGS-1:0] RW,
  output logic [NREGS-1:0] EA,
  output logic [W-1:0]     D,
  input  logic [W-1:0]     QA
);
  typedef enum logic [2:0] {IDLE, WR, RD_EN, RD_CAP, RSP} state_t;
  state_t state;
  logic [IDXW-1:0] idx;
  logic [NREGS-1:0] sel, req_sel;
  logic req_oor;
`ifdef WRITE_READBACK_EN
  logic wr;
  logic [W-1:0] wdata;
`endif
  assign sel = NREGS'(1) << idx;
  assign req_sel = NREGS'(1) << req_idx;
  assign req_oor = {1'b0, req_idx} >= (IDXW+1)'(NREGS);
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      RW <= '1;
      EA <= '0;
      D <= '0;
      idx <= '0;
`ifdef WRITE_READBACK_EN
      wr <= 1'b0;
      wdata <= '0;
`endif
    end else begin
      case (state)
        IDLE:
          if (req_ready && req_valid) begin
            idx <= req_idx;
            req_ready <= 1'b0;
`ifdef WRITE_READBACK_EN
            wr <= req_wr;
            wdata <= req_wdata;
`endif
            if (req_oor) begin
              state <= RSP;
              rsp_valid <= 1'b1;
              rsp_err <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_wr) begin
              state <= WR;
              RW <= ~req_sel;
              D <= req_wdata;
            end else begin
              state <= RD_EN;
              EA <= req_sel;
            end
          end else req_ready <= 1'b1;
        WR: begin
          RW <= '1;
`ifdef WRITE_READBACK_EN
          state <= RD_EN;
          EA <= sel;
`else
          state <= RSP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err <= 1'b0;
`endif
        end
        RD_EN: state <= RD_CAP;
        RD_CAP: begin
          state <= RSP;
          EA <= '0;
          rsp_valid <= 1'b1;
          rsp_rdata <= QA;
`ifdef WRITE_READBACK_EN
          rsp_err <= wr && (QA != wdata);
`else
          rsp_err <= 1'b0;
`endif
        end
        RSP:
          if (rsp_ready) begin
            state <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl: table-driven bench for reg_bank_ctrl with a behavioural register bank on RW/EA/D/QA
module tb_reg_bank_ctrl;
`ifdef WRITE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic CLK = 1'b0, CLR = 1'b1;
  logic req_valid = 1'b0, req_valid2 = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
  logic [1:0] req_idx = '0;
  logic [15:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, req_ready2, rsp_valid2, rsp_err2;
  logic [15:0] rsp_rdata, rsp_rdata2, D, D2, QA;
  logic [15:0] QA2 = '0;
  logic [3:0] RW, EA;
  logic [2:0] RW2, EA2;
  logic [15:0] regs [4];
  logic corrupt = 1'b0;
  logic [15:0] last_d = '0;
  int errs = 0, checks = 0;

  always #5 CLK = ~CLK;

  reg_bank_ctrl dut (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_idx(req_idx), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .RW(RW), .EA(EA), .D(D), .QA(QA)
  );

  reg_bank_ctrl #(.NREGS(3), .W(16), .IDXW(2)) dut3 (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid2), .req_ready(req_ready2), .req_wr(req_wr),
    .req_idx(req_idx), .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .RW(RW2), .EA(EA2), .D(D2), .QA(QA2)
  );

  always @(posedge CLK)
    for (int i = 0; i < 4; i++) if (!RW[i]) regs[i] <= D;

  always_comb begin
    QA = '0;
    for (int i = 0; i < 4; i++) if (EA[i]) QA = regs[i] & (corrupt ? 16'hFFF0 : 16'hFFFF);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input logic wr, input logic [1:0] idx, input logic [15:0] wd,
                     input logic [15:0] exp_rd, input logic exp_err, input int hold);
    int lat, rw_cyc, ea_cyc, n;
    logic bad;
    logic [15:0] rd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_idx = idx; req_wdata = wd;
    lat = 0; rw_cyc = 0; ea_cyc = 0; bad = 1'b0;
    do begin
      @(negedge CLK);
      lat++;
      req_valid = 1'b0;
      if (req_ready && !rsp_valid) bad = 1'b1;
      if (RW != 4'hF) begin
        rw_cyc++;
        if (RW !== ~(4'b0001 << idx) || D !== wd) bad = 1'b1;
      end
      if (EA != 4'h0) begin
        ea_cyc++;
        if (EA !== (4'b0001 << idx) || RW != 4'hF) bad = 1'b1;
      end
    end while (!rsp_valid && lat < 20);
    chk("latency", lat, wr ? (RB ? 4 : 2) : 3);
    chk("rw_cycles", rw_cyc, wr ? 1 : 0);
    chk("ea_cycles", ea_cyc, (!wr || RB) ? 2 : 0);
    chk("strobe_shape", bad, 0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    rd = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("hold_flags", {rsp_valid, req_ready, RW, EA}, {2'b10, 4'hF, 4'h0});
      chk("hold_rdata", rsp_rdata, rd);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("handshake", {rsp_valid, req_ready}, 2'b01);
    if (wr) last_d = wd;
    chk("d_hold", D, last_d);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  idx;
    logic [15:0] wd;
    logic [15:0] rd;
    int          hold;
  } vec_t;
  vec_t v[8];

  initial begin
    int n;
    v[0] = '{1'b1, 2'd1, 16'h00AA, 16'h0000, 0};
    v[1] = '{1'b0, 2'd1, 16'h0000, 16'h00AA, 0};
    v[2] = '{1'b1, 2'd2, 16'hBEEF, 16'h0000, 0};
    v[3] = '{1'b0, 2'd2, 16'h0000, 16'hBEEF, 5};
    v[4] = '{1'b1, 2'd0, 16'h1234, 16'h0000, 0};
    v[5] = '{1'b1, 2'd3, 16'hFFFF, 16'h0000, 2};
    v[6] = '{1'b0, 2'd0, 16'h0000, 16'h1234, 0};
    v[7] = '{1'b0, 2'd3, 16'h0000, 16'hFFFF, 0};
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state", {RW, EA, D, req_ready, rsp_valid}, {4'hF, 4'h0, 16'h0, 2'b00});
    CLR = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", {req_ready, rsp_valid}, 2'b10);
    req_wr = 1'b1; req_idx = 2'd3; req_wdata = 16'hDEAD; req_valid2 = 1'b1;
    @(negedge CLK);
    req_valid2 = 1'b0;
    chk("oor_rsp", {rsp_valid2, rsp_err2, rsp_rdata2}, {2'b11, 16'h0});
    chk("oor_strobe", {RW2, EA2, req_ready2}, {3'b111, 3'b000, 1'b0});
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("oor_done", {rsp_valid2, req_ready2, RW2, EA2}, {2'b01, 3'b111, 3'b000});
    for (int i = 0; i < 8; i++)
      txn(v[i].wr, v[i].idx, v[i].wd, v[i].wr ? (RB ? v[i].wd : 16'h0) : v[i].rd, 1'b0, v[i].hold);
    req_valid = 1'b1; req_wr = 1'b0; req_idx = 2'd1;
    n = 0;
    do begin @(negedge CLK); n++; req_valid = 1'b0; end while (!rsp_valid && n < 20);
    chk("b2b_read", {rsp_valid, rsp_rdata}, {1'b1, 16'h00AA});
    rsp_ready = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_idx = 2'd2; req_wdata = 16'h5A5A;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("b2b_idle", {rsp_valid, req_ready}, 2'b01);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("b2b_accept", {RW, D, req_ready}, {4'b1011, 16'h5A5A, 1'b0});
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge CLK); n++; end
    chk("b2b_rsp", {rsp_valid, rsp_err}, 2'b10);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    last_d = 16'h5A5A;
    txn(1'b0, 2'd2, 16'h0, 16'h5A5A, 1'b0, 0);
    req_valid = 1'b1; req_wr = 1'b0; req_idx = 2'd2;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("rd_en_ea", {EA, RW}, {4'b0100, 4'hF});
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_mid_rd", {EA, RW, D, rsp_valid, req_ready}, {4'h0, 4'hF, 16'h0, 2'b00});
    n = 0;
    repeat (5) begin @(negedge CLK); if (rsp_valid) n++; end
    chk("clr_no_rsp", n, 0);
    last_d = 16'h0;
`ifdef WRITE_READBACK_EN
    corrupt = 1'b1;
    txn(1'b1, 2'd0, 16'h1234, 16'h1230, 1'b1, 0);
    corrupt = 1'b0;
    txn(1'b1, 2'd1, 16'h4321, 16'h4321, 1'b0, 0);
`endif
    txn(1'b0, 2'd2, 16'h0, 16'h5A5A, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
